// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU control encodings,
// forward-source select and default datapath widths.
package id_ex_stage_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_LUI = 4'b1011,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXM   = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one source index: EX/MEM beats MEM/WB, and register 0
// is never forwarded so it always reads as the register-file value.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (idx != '0) begin
      if (exm_reg_write && (exm_rd == idx)) begin
        sel = FWD_EXM;
      end else if (memwb_reg_write && (memwb_rd == idx)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EXM:   data = exm_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall control, operand forwarding and
// load-use interlock. Define FORWARD_EN to enable forwarding and the interlock.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_shift_var,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [4:0]        alu_shamt,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              hold_id
);

  logic              ex_valid_q,      ex_valid_d;
  logic              ex_reg_write_q,  ex_reg_write_d;
  logic              ex_mem_read_q,   ex_mem_read_d;
  logic              ex_mem_write_q,  ex_mem_write_d;
  logic              ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [REG_AW-1:0] ex_rd_q,         ex_rd_d;
  logic [3:0]        alu_ctrl_q,      alu_ctrl_d;
  logic              alu_src_q,       alu_src_d;
  logic              shift_var_q,     shift_var_d;
  logic [DATA_W-1:0] rs_data_q,       rs_data_d;
  logic [DATA_W-1:0] rt_data_q,       rt_data_d;
  logic [DATA_W-1:0] imm_q,           imm_d;
  logic [4:0]        shamt_q,         shamt_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              load_use;

`ifdef FORWARD_EN
  logic [REG_AW-1:0] rs_idx_q, rs_idx_d;
  logic [REG_AW-1:0] rt_idx_q, rt_idx_d;

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx             (rs_idx_q),
    .rf_data         (rs_data_q),
    .exm_reg_write   (exm_reg_write),
    .exm_rd          (exm_rd),
    .exm_result      (exm_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_rs)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx             (rt_idx_q),
    .rf_data         (rt_data_q),
    .exm_reg_write   (exm_reg_write),
    .exm_rd          (exm_rd),
    .exm_result      (exm_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_rt)
  );

  // A load in EX cannot forward its data until MEM/WB, so a dependent ID op waits one cycle.
  assign load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & id_valid &
                    ((ex_rd_q == id_rs) | (ex_rd_q == id_rt));
`else
  logic unused_fwd_inputs;

  assign fwd_rs   = rs_data_q;
  assign fwd_rt   = rt_data_q;
  assign load_use = 1'b0;
  assign unused_fwd_inputs = ^{id_rs, id_rt, exm_reg_write, exm_rd, exm_result,
                               memwb_reg_write, memwb_rd, memwb_result};
`endif

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_mem_to_reg_d = ex_mem_to_reg_q;
    ex_rd_d         = ex_rd_q;
    alu_ctrl_d      = alu_ctrl_q;
    alu_src_d       = alu_src_q;
    shift_var_d     = shift_var_q;
    rs_data_d       = rs_data_q;
    rt_data_d       = rt_data_q;
    imm_d           = imm_q;
    shamt_d         = shamt_q;
`ifdef FORWARD_EN
    rs_idx_d        = rs_idx_q;
    rt_idx_d        = rt_idx_q;
`endif

    if (flush) begin
      ex_valid_d      = 1'b0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_mem_to_reg_d = 1'b0;
    end else if (stall_in) begin
`ifdef FORWARD_EN
      // Capture any forward hit now: the producer may retire before the hold ends.
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
`endif
    end else if (load_use) begin
      ex_valid_d      = 1'b0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
      ex_mem_to_reg_d = 1'b0;
    end else begin
      ex_valid_d      = id_valid;
      ex_reg_write_d  = id_valid & id_reg_write;
      ex_mem_read_d   = id_valid & id_mem_read;
      ex_mem_write_d  = id_valid & id_mem_write;
      ex_mem_to_reg_d = id_valid & id_mem_to_reg;
      ex_rd_d         = id_rd;
      alu_ctrl_d      = id_alu_ctrl;
      alu_src_d       = id_alu_src;
      shift_var_d     = id_shift_var;
      rs_data_d       = id_rs_data;
      rt_data_d       = id_rt_data;
      imm_d           = id_imm;
      shamt_d         = id_shamt;
`ifdef FORWARD_EN
      rs_idx_d        = id_rs;
      rt_idx_d        = id_rt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_rd_q         <= '0;
      alu_ctrl_q      <= '0;
      alu_src_q       <= 1'b0;
      shift_var_q     <= 1'b0;
      rs_data_q       <= '0;
      rt_data_q       <= '0;
      imm_q           <= '0;
      shamt_q         <= '0;
`ifdef FORWARD_EN
      rs_idx_q        <= '0;
      rt_idx_q        <= '0;
`endif
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_rd_q         <= ex_rd_d;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_src_q       <= alu_src_d;
      shift_var_q     <= shift_var_d;
      rs_data_q       <= rs_data_d;
      rt_data_q       <= rt_data_d;
      imm_q           <= imm_d;
      shamt_q         <= shamt_d;
`ifdef FORWARD_EN
      rs_idx_q        <= rs_idx_d;
      rt_idx_q        <= rt_idx_d;
`endif
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_rd         = ex_rd_q;
  assign alu_ctrl      = alu_ctrl_q;

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_shamt     = shift_var_q ? fwd_rs[4:0] : shamt_q;

  // Must act in the current cycle to freeze fetch/decode; forced low while in reset.
  assign hold_id = rst_n & (stall_in | load_use);

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic against
// a behavioural model of the EX slot. Follows the FORWARD_EN build setting.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic [3:0] id_alu_ctrl;
  logic id_alu_src, id_shift_var, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic flush, stall_in;
  logic exm_reg_write, memwb_reg_write;
  logic [4:0] exm_rd, memwb_rd;
  logic [31:0] exm_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0] alu_ctrl;
  logic [4:0] alu_shamt, ex_rd;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hold_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_shift_var(id_shift_var),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush), .stall_in(stall_in),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .hold_id(hold_id)
  );

  // Reference model: the instruction currently occupying the EX slot.
  typedef struct packed {
    logic valid, rw, mr, mw, m2r, src, sv;
    logic [4:0] rd, rs, rt, shamt;
    logic [3:0] ctrl;
    logic [31:0] rsv, rtv, imm;
  } slot_t;

  slot_t m, mn;

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] stored);
    if (FWD && idx != 5'd0) begin
      if (exm_reg_write && exm_rd == idx) return exm_result;
      if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    end
    return stored;
  endfunction

  function automatic bit lu_hazard();
    return FWD && m.valid && m.mr && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs || m.rd == id_rt);
  endfunction

  function automatic slot_t next_slot();
    slot_t n = m;
    if (flush) begin
      {n.valid, n.rw, n.mr, n.mw, n.m2r} = 5'b0;
    end else if (stall_in) begin
      n.rsv = fwd_val(m.rs, m.rsv);
      n.rtv = fwd_val(m.rt, m.rtv);
    end else if (lu_hazard()) begin
      {n.valid, n.rw, n.mr, n.mw, n.m2r} = 5'b0;
    end else begin
      n.valid = id_valid;
      n.rw = id_valid & id_reg_write;
      n.mr = id_valid & id_mem_read;
      n.mw = id_valid & id_mem_write;
      n.m2r = id_valid & id_mem_to_reg;
      n.src = id_alu_src; n.sv = id_shift_var;
      n.rd = id_rd; n.rs = id_rs; n.rt = id_rt; n.shamt = id_shamt;
      n.ctrl = id_alu_ctrl;
      n.rsv = id_rs_data; n.rtv = id_rt_data; n.imm = id_imm;
    end
    return n;
  endfunction

  task automatic clear_inputs();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_alu_ctrl = 0;
    id_alu_src = 0; id_shift_var = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; flush = 0; stall_in = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    stall_in = 1;
    rst_n = 0;
    #3;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, alu_ctrl} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %h expected 0", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, alu_ctrl});
    end
    checks++;
    if ({alu_a, alu_b, ex_store_data, alu_shamt} !== 101'd0) begin
      errors++;
      $display("FAIL reset_operands: got %h expected 0", {alu_a, alu_b, ex_store_data, alu_shamt});
    end
    checks++;
    if (hold_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_id: got %b expected 0", hold_id);
    end
    stall_in = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_rs = 1; id_rt = 8; id_rd = 8; id_alu_ctrl = ALU_ADD; id_alu_src = 1; id_imm = 4;
    @(posedge clk); #1;
    id_mem_read = 0; id_mem_to_reg = 0; id_alu_src = 0;
    id_rs = 8; id_rt = 9; id_rd = 10; id_rs_data = 32'h1234; id_rt_data = 32'h1;
    #1;
    checks++;
    if (hold_id !== FWD) begin
      errors++;
      $display("FAIL load_use_hold: got %b expected %b", hold_id, FWD);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== !FWD) begin
      errors++;
      $display("FAIL load_use_bubble: ex_valid got %b expected %b", ex_valid, !FWD);
    end
    checks++;
    if (hold_id !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: hold_id got %b expected 0", hold_id);
    end
    @(posedge clk); #1;
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'hCAFE;
    #1;
    checks++;
    if ({ex_valid, ex_rd} !== {1'b1, 5'd10}) begin
      errors++;
      $display("FAIL load_use_enter: got valid=%b rd=%0d expected valid=1 rd=10", ex_valid, ex_rd);
    end
    checks++;
    if (alu_a !== (FWD ? 32'hCAFE : 32'h1234)) begin
      errors++;
      $display("FAIL load_use_fwd: alu_a got %h expected %h", alu_a, FWD ? 32'hCAFE : 32'h1234);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs = 5; id_rt = 5; id_rd = 6;
    id_rs_data = 32'h99; id_rt_data = 32'h98; id_alu_ctrl = ALU_ADD;
    @(posedge clk); #1;
    clear_inputs();
    exm_reg_write = 1; exm_rd = 5; exm_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h22;
    #1;
    checks++;
    if (alu_a !== (FWD ? 32'h11 : 32'h99)) begin
      errors++;
      $display("FAIL priority_a: alu_a got %h expected %h", alu_a, FWD ? 32'h11 : 32'h99);
    end
    checks++;
    if (alu_b !== (FWD ? 32'h11 : 32'h98)) begin
      errors++;
      $display("FAIL priority_b: alu_b got %h expected %h", alu_b, FWD ? 32'h11 : 32'h98);
    end
    exm_reg_write = 0;
    #1;
    checks++;
    if (alu_a !== (FWD ? 32'h22 : 32'h99)) begin
      errors++;
      $display("FAIL memwb_a: alu_a got %h expected %h", alu_a, FWD ? 32'h22 : 32'h99);
    end
    checks++;
    if (ex_store_data !== (FWD ? 32'h22 : 32'h98)) begin
      errors++;
      $display("FAIL memwb_store: got %h expected %h", ex_store_data, FWD ? 32'h22 : 32'h98);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rd = 4; id_rs = 0; id_rt = 0;
    id_alu_src = 1; id_imm = 32'h7; id_shift_var = 1; id_shamt = 5'd9;
    @(posedge clk); #1;
    clear_inputs();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBEEF;
    #1;
    checks++;
    if ({alu_a, ex_store_data} !== 64'd0) begin
      errors++;
      $display("FAIL zero_reg: alu_a=%h store=%h expected 0 and 0", alu_a, ex_store_data);
    end
    checks++;
    if ({alu_b, alu_shamt} !== {32'h7, 5'd0}) begin
      errors++;
      $display("FAIL zero_reg_imm: alu_b=%h shamt=%0d expected 7 and 0", alu_b, alu_shamt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_rd = 7;
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b111) begin
      errors++;
      $display("FAIL flush_setup: got %b expected 111", {ex_valid, ex_reg_write, ex_mem_write});
    end
    flush = 1; stall_in = 1;
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL flush_over_stall: got %b expected 000", {ex_valid, ex_reg_write, ex_mem_write});
    end
    clear_inputs();
  endtask

  task automatic test_hold_refresh();
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_rs = 2; id_rs_data = 32'h100;
    id_rt = 3; id_rt_data = 32'h10; id_alu_src = 1; id_imm = 32'h8;
    @(posedge clk); #1;
    id_rd = 9; id_rt_data = 32'h77;
    stall_in = 1; memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h55;
    #1;
    checks++;
    if (hold_id !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold_id: got %b expected 1", hold_id);
    end
    @(posedge clk); #1;
    memwb_reg_write = 0; memwb_result = 0;
    #1;
    checks++;
    if (ex_store_data !== (FWD ? 32'h55 : 32'h10)) begin
      errors++;
      $display("FAIL hold_refresh: store got %h expected %h", ex_store_data, FWD ? 32'h55 : 32'h10);
    end
    @(posedge clk); #1;
    stall_in = 0; id_valid = 0;
    #1;
    checks++;
    if ({ex_store_data, alu_b, ex_mem_write} !== {(FWD ? 32'h55 : 32'h10), 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL hold_release: store=%h alu_b=%h mw=%b expected %h 8 1",
               ex_store_data, alu_b, ex_mem_write, FWD ? 32'h55 : 32'h10);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rd = 12; id_alu_ctrl = ALU_SUB;
    @(posedge clk); #1;
    stall_in = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, hold_id} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: ex_valid=%b hold_id=%b expected 0 0", ex_valid, hold_id);
    end
    checks++;
    if ({ex_reg_write, ex_rd, alu_ctrl} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_fields: got %h expected 0", {ex_reg_write, ex_rd, alu_ctrl});
    end
    stall_in = 0; id_rd = 13;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_rd} !== {1'b1, 1'b1, 5'd13}) begin
      errors++;
      $display("FAIL reset_release_load: got %b%b rd=%0d expected 11 rd=13", ex_valid, ex_reg_write, ex_rd);
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_ctl;
    logic [31:0] exp_a, exp_rt, exp_b;
    logic [4:0]  exp_sh;
    logic        exp_hold;
    clear_inputs();
    rst_n = 0;
    m = '0;
    @(negedge clk); rst_n = 1;
    mn = next_slot();
    @(posedge clk); m = mn; #1;
    for (int c = 0; c < 2000; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_shamt = 5'($urandom_range(0, 31));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alu_ctrl = 4'($urandom_range(0, 15));
      id_alu_src = 1'($urandom_range(0, 1)); id_shift_var = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0); stall_in = ($urandom_range(0, 5) == 0);
      exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3));
      exm_result = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      @(negedge clk);
      exp_ctl = {m.valid, m.rw, m.mr, m.mw, m.m2r, m.rd, m.ctrl};
      exp_a = fwd_val(m.rs, m.rsv);
      exp_rt = fwd_val(m.rt, m.rtv);
      exp_b = m.src ? m.imm : exp_rt;
      exp_sh = m.sv ? exp_a[4:0] : m.shamt;
      exp_hold = stall_in | lu_hazard();
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, alu_ctrl} !== exp_ctl) begin
        errors++;
        $display("FAIL rand_ctl cycle %0d: got %h expected %h", c,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, alu_ctrl}, exp_ctl);
      end
      checks++;
      if ({alu_a, alu_b, alu_shamt, ex_store_data} !== {exp_a, exp_b, exp_sh, exp_rt}) begin
        errors++;
        $display("FAIL rand_operands cycle %0d: got a=%h b=%h sh=%0d st=%h expected a=%h b=%h sh=%0d st=%h",
                 c, alu_a, alu_b, alu_shamt, ex_store_data, exp_a, exp_b, exp_sh, exp_rt);
      end
      checks++;
      if (hold_id !== exp_hold) begin
        errors++;
        $display("FAIL rand_hold cycle %0d: got %b expected %b", c, hold_id, exp_hold);
      end
      mn = next_slot();
      @(posedge clk); m = mn; #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_flush_stall();
    test_hold_refresh();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operands and results.
REQ-002 Parameter REG_AW, default 5, register-index width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_rs_data, id_rt_data, id_imm  in  DATA_W each  register-file reads and extended immediate.
REQ-007 id_rs, id_rt, id_rd  in  REG_AW each  source/destination indices; id_shamt in 5 static shift amount.
REQ-008 id_alu_ctrl in 4; id_alu_src, id_shift_var, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in 1 each  decoded controls.
REQ-009 flush  in  1  squash the EX slot (branch/jump redirect); stall_in  in  1  downstream hold.
REQ-010 exm_reg_write in 1, exm_rd in REG_AW, exm_result in DATA_W  EX/MEM writeback source; memwb_reg_write, memwb_rd, memwb_result likewise for MEM/WB.
REQ-011 alu_a, alu_b  out  DATA_W  ALU operands; alu_ctrl out 4; alu_shamt out 5.
REQ-012 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out 1; ex_rd out REG_AW; ex_store_data out DATA_W.
REQ-013 hold_id  out  1  decode and fetch shall not advance this cycle.

Function
REQ-014 Stage update priority per edge: flush > stall_in > load-use bubble > load from ID.
REQ-015 flush: ex_valid<=0 and all ex_* write/read enables <=0 next edge, regardless of stall_in.
REQ-016 stall_in (no flush): all stage registers hold, except operand refresh per REQ-021; hold_id=1.
REQ-017 Load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt); then bubble inserted (ex_valid<=0, enables<=0), hold_id=1; one-cycle penalty exactly.
REQ-018 Normal load: all ID fields captured; ex_valid<=id_valid; enables gated by id_valid; hold_id=0.
REQ-019 Forwarding, per operand (rs, rt): EX/MEM match (exm_reg_write & exm_rd!=0 & exm_rd==idx) wins over MEM/WB match; otherwise registered register-file value; index 0 never forwarded.
REQ-020 alu_a = forwarded rs; alu_b = id_alu_src ? registered imm : forwarded rt; ex_store_data = forwarded rt; alu_shamt = shift_var ? forwarded rs[4:0] : registered shamt.
REQ-021 While held by stall_in, a matching forward source overwrites the stored rs/rt operand each edge, so a MEM/WB value retiring during the hold is not lost.
REQ-022 Outputs alu_a/alu_b/alu_shamt/ex_store_data combinational from stage registers and forward inputs; all other outputs registered.

Reset
REQ-023 rst_n low: ex_valid, all enables, ex_rd, alu_ctrl, stored operands, imm, shamt = 0 immediately; hold_id=0.
REQ-024 Reset asserted mid-hold or mid-bubble discards the held instruction; first edge after release behaves as REQ-018.

Configuration
REQ-025 Macro FORWARD_EN defined: REQ-017, REQ-019, REQ-021 active.
REQ-026 FORWARD_EN undefined: no forwarding (operands = stored register-file values), no load-use detection, hold_id = stall_in; software schedules hazards.

Structure
REQ-027 Shared package holds ALU control encodings (AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, LUI 1011, NOR 1100), forward-select enum {FWD_RF, FWD_EXM, FWD_MEMWB}, DATA_W/REG_AW defaults.
REQ-028 One sub-module fwd_unit: index compare and select for one operand, instantiated twice (rs, rt).

Verification
REQ-029 Load-use: ex holds lw rd=8, ID add rs=8 -> hold_id=1 one cycle, bubble (ex_valid=0), next cycle add enters with alu_a=memwb_result.
REQ-030 Priority: exm_rd=memwb_rd=5, exm_result=0x11, memwb_result=0x22, id_rs=5 -> alu_a=0x11.
REQ-031 Zero register: exm_rd=0, exm_reg_write=1, exm_result=0xDEAD, rs=0, id_rs_data=0 -> alu_a=0.
REQ-032 Flush with stall_in=1 -> ex_valid=0, ex_reg_write=0 next edge.
REQ-033 Hold refresh: stall_in 2 cycles, memwb_rd=rt=3, memwb_result=0x55 first cycle only -> after release ex_store_data=0x55.
REQ-034 Async reset mid-stall, rst_n low between edges -> ex_valid=0 and hold_id=0 without waiting for clk.
